// File: rtl/pkt_sche_drain.sv
// pkt_sche_drain: egress drain controller downstream of the packet scheduler.
// Pops show-ahead words from the scheduler, shapes the pop rate with a token
// bucket, buffers words in a small holding FIFO and presents them on a
// valid/ready transmit interface.
// Optional build macro: PKT_DRAIN_STATS_EN enables the stat_sent/stat_stall
// counters; without it both stat outputs are tied to zero.
module pkt_sche_drain #(
    parameter int DWIDTH   = 32,
    parameter int DEPTH    = 4,
    parameter int TOKEN_W  = 8,
    parameter int PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [PERIOD_W-1:0] cfg_period,
    input  logic [TOKEN_W-1:0]  cfg_burst,
    input  logic                sch_ready,
    input  logic                sch_out_valid,
    input  logic [DWIDTH-1:0]   sch_out_data,
    output logic                sch_out_deque_en,
    output logic                tx_valid,
    output logic [DWIDTH-1:0]   tx_data,
    input  logic                tx_ready,
    output logic                busy,
    output logic [31:0]         stat_sent,
    output logic [31:0]         stat_stall
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        ST_WAIT_RDY = 2'd0,
        ST_RUN      = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_HALT     = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [CW-1:0]       count_r;
    logic [CW-1:0]       count_s;
    logic [CW-1:0]       count_after_s;
    logic [AW-1:0]       rd_ptr_r;
    logic [AW-1:0]       rd_ptr_s;
    logic [AW-1:0]       wr_ptr_r;
    logic [AW-1:0]       wr_ptr_s;
    logic [DWIDTH-1:0]   mem_r [DEPTH];
    logic [TOKEN_W-1:0]  tokens_r;
    logic [TOKEN_W-1:0]  tokens_s;
    logic [TOKEN_W:0]    tok_sum_s;
    logic [PERIOD_W-1:0] pcnt_r;
    logic [PERIOD_W-1:0] pcnt_s;
    logic                refill_s;
    logic                shaping_s;
    logic                run_room_r;
    logic                run_room_s;
    logic                tx_valid_r;
    logic [DWIDTH-1:0]   tx_data_r;
    logic [DWIDTH-1:0]   head_s;
    logic                busy_r;
    logic                busy_s;
    logic                pop_s;
    logic                retire_s;

    // The pop request combines the registered "running with room" flag with
    // the token check, so a pop can never be granted on an empty bucket and
    // it never looks at sch_out_valid.
    assign shaping_s        = (cfg_period != {PERIOD_W{1'b0}});
    assign sch_out_deque_en = run_room_r && (!shaping_s || (tokens_r != {TOKEN_W{1'b0}}));
    assign pop_s            = sch_out_valid && sch_out_deque_en;
    assign retire_s         = tx_valid_r && tx_ready;

    assign tx_valid = tx_valid_r;
    assign tx_data  = tx_data_r;
    assign busy     = busy_r;

    // Next-state logic of the drain control FSM.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_WAIT_RDY: begin
                if (sch_ready && en) begin
                    state_s = ST_RUN;
                end else if (sch_ready) begin
                    state_s = ST_HALT;
                end else begin
                    state_s = ST_WAIT_RDY;
                end
            end
            ST_RUN: begin
                if (!en) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (en) begin
                    state_s = ST_RUN;
                end else if (count_r == {CW{1'b0}}) begin
                    state_s = ST_HALT;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_HALT: begin
                if (en) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_HALT;
                end
            end
            default: begin
                state_s = ST_WAIT_RDY;
            end
        endcase
    end

    // FIFO occupancy, pointers and the head word visible after this edge.
    always_comb begin
        case ({pop_s, retire_s})
            2'b10:   count_s = count_r + CW'(1'b1);
            2'b01:   count_s = count_r - CW'(1'b1);
            default: count_s = count_r;
        endcase
        if (retire_s) begin
            rd_ptr_s      = rd_ptr_r + AW'(1'b1);
            count_after_s = count_r - CW'(1'b1);
        end else begin
            rd_ptr_s      = rd_ptr_r;
            count_after_s = count_r;
        end
        if (pop_s) begin
            wr_ptr_s = wr_ptr_r + AW'(1'b1);
        end else begin
            wr_ptr_s = wr_ptr_r;
        end
        // When the FIFO would otherwise be empty the incoming word becomes
        // the head directly; an empty FIFO keeps the last presented word.
        if (count_after_s == {CW{1'b0}}) begin
            if (pop_s) begin
                head_s = sch_out_data;
            end else begin
                head_s = tx_data_r;
            end
        end else begin
            head_s = mem_r[rd_ptr_s];
        end
    end

    // Token bucket: refill on period wrap, spend one token per pop, clip at burst.
    always_comb begin
        pcnt_s    = pcnt_r;
        refill_s  = 1'b0;
        tok_sum_s = {1'b0, tokens_r};
        tokens_s  = tokens_r;
        if (shaping_s) begin
            if (pcnt_r >= (cfg_period - PERIOD_W'(1'b1))) begin
                pcnt_s   = {PERIOD_W{1'b0}};
                refill_s = 1'b1;
            end else begin
                pcnt_s   = pcnt_r + PERIOD_W'(1'b1);
                refill_s = 1'b0;
            end
            tok_sum_s = {1'b0, tokens_r} - {{TOKEN_W{1'b0}}, pop_s} + {{TOKEN_W{1'b0}}, refill_s};
            if (tok_sum_s > {1'b0, cfg_burst}) begin
                tokens_s = cfg_burst;
            end else begin
                tokens_s = tok_sum_s[TOKEN_W-1:0];
            end
        end else begin
            tokens_s = tokens_r;
        end
    end

    // Values of the registered outputs as seen after this edge.
    always_comb begin
        run_room_s = (state_s == ST_RUN) && (count_s < CW'(DEPTH));
        busy_s     = (state_s == ST_RUN) || (state_s == ST_DRAIN);
    end

    // Control, bucket and output registers; reset discards buffered words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_WAIT_RDY;
            count_r    <= {CW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            wr_ptr_r   <= {AW{1'b0}};
            tokens_r   <= {TOKEN_W{1'b0}};
            pcnt_r     <= {PERIOD_W{1'b0}};
            run_room_r <= 1'b0;
            tx_valid_r <= 1'b0;
            tx_data_r  <= {DWIDTH{1'b0}};
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            count_r    <= count_s;
            rd_ptr_r   <= rd_ptr_s;
            wr_ptr_r   <= wr_ptr_s;
            tokens_r   <= tokens_s;
            pcnt_r     <= pcnt_s;
            run_room_r <= run_room_s;
            tx_valid_r <= (count_s != {CW{1'b0}});
            tx_data_r  <= head_s;
            busy_r     <= busy_s;
        end
    end

    // Holding FIFO storage; contents are don't-care while not counted.
    always_ff @(posedge clk) begin
        if (pop_s) begin
            mem_r[wr_ptr_r] <= sch_out_data;
        end
    end

`ifdef PKT_DRAIN_STATS_EN
    logic [31:0] stat_sent_r;
    logic [31:0] stat_stall_r;

    // Transmitted-word and backpressure-cycle counters, wrapping at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_sent_r  <= 32'd0;
            stat_stall_r <= 32'd0;
        end else begin
            if (retire_s) begin
                stat_sent_r <= stat_sent_r + 32'd1;
            end
            if (tx_valid_r && !tx_ready) begin
                stat_stall_r <= stat_stall_r + 32'd1;
            end
        end
    end

    assign stat_sent  = stat_sent_r;
    assign stat_stall = stat_stall_r;
`else
    assign stat_sent  = 32'd0;
    assign stat_stall = 32'd0;
`endif

endmodule

// File: tb/tb_pkt_sche_drain.sv
// Self-checking bench for pkt_sche_drain: a table-driven streaming test,
// directed multi-cycle sequences, and a randomized phase, all compared
// every cycle against a queue-based reference model of the drain rules.
module tb_pkt_sche_drain;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int TW    = 8;
    localparam int PW    = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [PW-1:0] cfg_period;
    logic [TW-1:0] cfg_burst;
    logic          sch_ready;
    logic          sch_out_valid;
    logic [DW-1:0] sch_out_data;
    logic          sch_out_deque_en;
    logic          tx_valid;
    logic [DW-1:0] tx_data;
    logic          tx_ready;
    logic          busy;
    logic [31:0]   stat_sent;
    logic [31:0]   stat_stall;

    always #5 clk = ~clk;

    pkt_sche_drain #(.DWIDTH(DW), .DEPTH(DEPTH), .TOKEN_W(TW), .PERIOD_W(PW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .cfg_period(cfg_period), .cfg_burst(cfg_burst),
        .sch_ready(sch_ready), .sch_out_valid(sch_out_valid), .sch_out_data(sch_out_data),
        .sch_out_deque_en(sch_out_deque_en), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(tx_ready), .busy(busy), .stat_sent(stat_sent), .stat_stall(stat_stall)
    );

    typedef struct {
        bit          en;
        bit          offer;
        bit          rdy;
        bit          exp_deq;
        bit          exp_txv;
        logic [31:0] exp_txd;
    } vec_t;
    vec_t tbl [10];

    typedef enum {M_WAIT, M_RUN, M_DRAIN, M_HALT} mstate_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [31:0] src_data;
    int          src_left;
    bit          src_on;
    bit          src_rand;
    bit          pend_pop;
    logic [31:0] rx_q [$];
    int          pop_cyc [$];

    mstate_t     m_state;
    logic [31:0] m_q [$];
    int          m_tokens;
    int          m_pcnt;
    int unsigned m_sent;
    int unsigned m_stall;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_bit(input string name, input bit act, input bit exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b, expected %0b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] exp_stat(input int unsigned v);
`ifdef PKT_DRAIN_STATS_EN
        return v;
`else
        return 32'd0;
`endif
    endfunction

    function automatic bit m_deq();
        return (m_state == M_RUN) && (m_q.size() < DEPTH) && (cfg_period == 0 || m_tokens != 0);
    endfunction

    task automatic model_reset();
        m_state  = M_WAIT;
        m_q.delete();
        m_tokens = 0;
        m_pcnt   = 0;
        m_sent   = 0;
        m_stall  = 0;
    endtask

    // One clock edge of the reference behaviour, using the pre-edge inputs.
    task automatic model_step();
        int n0;
        bit pop;
        bit ret;
        bit refill;
        int t;
        n0  = m_q.size();
        pop = sch_out_valid && m_deq();
        ret = (n0 != 0) && tx_ready;
        if (n0 != 0 && !tx_ready) m_stall++;
        if (ret) begin
            void'(m_q.pop_front());
            m_sent++;
        end
        if (pop) m_q.push_back(sch_out_data);
        if (cfg_period != 0) begin
            refill   = (m_pcnt >= int'(cfg_period) - 1);
            m_pcnt   = refill ? 0 : m_pcnt + 1;
            t        = m_tokens - int'(pop) + int'(refill);
            m_tokens = (t > int'(cfg_burst)) ? int'(cfg_burst) : t;
        end
        case (m_state)
            M_WAIT:  if (sch_ready) m_state = en ? M_RUN : M_HALT;
            M_RUN:   if (!en) m_state = M_DRAIN;
            M_DRAIN: if (en) m_state = M_RUN; else if (n0 == 0) m_state = M_HALT;
            M_HALT:  if (en) m_state = M_RUN;
            default: m_state = M_WAIT;
        endcase
    endtask

    // Drive the source, then compare every output with the model.
    task automatic pre();
        sch_out_valid = src_on && (src_left > 0) && (!src_rand || $urandom_range(0, 1) == 1);
        sch_out_data  = src_data;
        #1;
        chk_bit("deque_en", sch_out_deque_en, m_deq());
        chk_bit("tx_valid", tx_valid, m_q.size() != 0);
        if (m_q.size() != 0) chk32("tx_data", tx_data, m_q[0]);
        chk_bit("busy", busy, (m_state == M_RUN) || (m_state == M_DRAIN));
        chk32("stat_sent", stat_sent, exp_stat(m_sent));
        chk32("stat_stall", stat_stall, exp_stat(m_stall));
        if (tx_valid && tx_ready) rx_q.push_back(tx_data);
        pend_pop = sch_out_valid && sch_out_deque_en;
        if (pend_pop) pop_cyc.push_back(cyc);
    endtask

    task automatic post();
        @(posedge clk);
        model_step();
        if (pend_pop) begin
            src_data = src_data + 32'd1;
            src_left--;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic cycle(input int n);
        for (int k = 0; k < n; k++) begin
            pre();
            post();
        end
    endtask

    task automatic chk_rx(input string name, input logic [31:0] base, input int n);
        chk32({name, "_count"}, 32'(rx_q.size()), 32'(n));
        for (int k = 0; k < n && k < rx_q.size(); k++) begin
            chk32(name, rx_q[k], base + 32'(k));
        end
    endtask

    task automatic chk_reset_outputs(input string name);
        chk_bit({name, "_deq"}, sch_out_deque_en, 1'b0);
        chk_bit({name, "_txv"}, tx_valid, 1'b0);
        chk_bit({name, "_busy"}, busy, 1'b0);
        chk32({name, "_txd"}, tx_data, 32'd0);
        chk32({name, "_sent"}, stat_sent, 32'd0);
        chk32({name, "_stall"}, stat_stall, 32'd0);
    endtask

    initial begin
        logic [31:0] gap;

        for (int i = 0; i < 10; i++) begin
            tbl[i].en      = 1'b1;
            tbl[i].offer   = (i < 8);
            tbl[i].rdy     = 1'b1;
            tbl[i].exp_deq = 1'b1;
            tbl[i].exp_txv = (i >= 1) && (i <= 8);
            tbl[i].exp_txd = 32'h10 + 32'(i) - 32'd1;
        end

        rst_n = 1'b0; en = 1'b0; sch_ready = 1'b0; tx_ready = 1'b1;
        cfg_period = 16'd0; cfg_burst = 8'd4;
        sch_out_valid = 1'b0; sch_out_data = 32'd0;
        src_data = 32'd0; src_left = 0; src_on = 1'b0; src_rand = 1'b0; pend_pop = 1'b0;
        model_reset();

        // Reset values, then scheduler not yet ready.
        @(negedge clk);
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            pre();
            chk_bit("wait_deq", sch_out_deque_en, 1'b0);
            chk_bit("wait_busy", busy, 1'b0);
            post();
        end
        sch_ready = 1'b1; en = 1'b1;
        cycle(1);
        pre();
        chk_bit("ready_deq", sch_out_deque_en, 1'b1);
        post();

        // Unshaped streaming of 0x10..0x17 from the vector table.
        src_data = 32'h10; src_left = 8; rx_q.delete();
        for (int i = 0; i < 10; i++) begin
            en = tbl[i].en; src_on = tbl[i].offer; tx_ready = tbl[i].rdy;
            pre();
            chk_bit("tbl_deq", sch_out_deque_en, tbl[i].exp_deq);
            chk_bit("tbl_txv", tx_valid, tbl[i].exp_txv);
            if (tbl[i].exp_txv) chk32("tbl_txd", tx_data, tbl[i].exp_txd);
            post();
        end
        chk_rx("stream_rx", 32'h10, 8);
        chk32("stream_sent", stat_sent, exp_stat(32'd8));

        // Backpressure: six words offered, only four fit.
        src_data = 32'h20; src_left = 6; src_on = 1'b1; tx_ready = 1'b0;
        rx_q.delete(); pop_cyc.delete();
        cycle(8);
        chk32("bp_pops", 32'(pop_cyc.size()), 32'd4);
        tx_ready = 1'b1;
        pre();
        chk_bit("bp_full_deq", sch_out_deque_en, 1'b0);
        chk32("bp_stall", stat_stall, exp_stat(32'd7));
        post();
        cycle(10);
        chk_rx("bp_rx", 32'h20, 6);

        // Shaped: period 4, burst 2, after a long idle.
        src_on = 1'b0; src_left = 0; cfg_period = 16'd4; cfg_burst = 8'd2;
        cycle(20);
        pop_cyc.delete();
        src_data = 32'h30; src_left = 12; src_on = 1'b1;
        cycle(30);
        chk_bit("shape_pops", pop_cyc.size() >= 6, 1'b1);
        if (pop_cyc.size() >= 6) begin
            gap = pop_cyc[1] - pop_cyc[0];
            chk32("shape_gap0", gap, 32'd1);
            gap = pop_cyc[2] - pop_cyc[1];
            chk_bit("shape_gap1", gap >= 32'd2 && gap <= 32'd4, 1'b1);
            for (int i = 2; i + 1 < pop_cyc.size(); i++) begin
                gap = pop_cyc[i+1] - pop_cyc[i];
                chk32("shape_gap", gap, 32'd4);
            end
        end
        src_on = 1'b0; src_left = 0; cfg_period = 16'd0;
        cycle(10);

        // Enable drop with three words buffered, then re-enable.
        rx_q.delete();
        src_data = 32'h40; src_left = 3; src_on = 1'b1; tx_ready = 1'b0;
        cycle(5);
        en = 1'b0; src_on = 1'b0;
        cycle(1);
        pop_cyc.delete();
        src_left = 5; src_on = 1'b1;
        cycle(2);
        tx_ready = 1'b1;
        cycle(6);
        chk32("drain_pops", 32'(pop_cyc.size()), 32'd0);
        chk_rx("drain_rx", 32'h40, 3);
        pre();
        chk_bit("halt_busy", busy, 1'b0);
        chk_bit("halt_deq", sch_out_deque_en, 1'b0);
        post();
        en = 1'b1;
        cycle(1);
        pre();
        chk_bit("resume_deq", sch_out_deque_en, 1'b1);
        post();
        chk32("resume_pops", 32'(pop_cyc.size()), 32'd1);

        // Asynchronous reset with two words buffered.
        src_on = 1'b0; src_left = 0;
        cycle(3);
        tx_ready = 1'b0; src_data = 32'h50; src_left = 2; src_on = 1'b1;
        cycle(4);
        chk_bit("pre_rst_txv", tx_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        model_reset();
        src_on = 1'b0; src_left = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rx_q.delete();
        tx_ready = 1'b1;
        cycle(6);
        chk32("midrst_rx", 32'(rx_q.size()), 32'd0);

        // Randomized traffic, backpressure, enable and shaping changes.
        src_rand = 1'b1; src_on = 1'b1; src_left = 1000000;
        for (int i = 0; i < 3000; i++) begin
            if (i % 64 == 0) begin
                cfg_period = 16'($urandom_range(0, 4));
                cfg_burst  = 8'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 19) == 0) en = ~en;
            tx_ready = ($urandom_range(0, 3) != 0);
            cycle(1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pkt_sche_drain.md
# pkt_sche_drain

Egress drain controller for the packet scheduler's output side. Pops address/data words from the scheduler's output buffer with the `out_valid` / `out_deque_en` show-ahead protocol, applies token-bucket rate shaping, buffers popped words in a small holding FIFO, and presents them on a valid/ready transmit interface toward the egress MAC or packet-memory reader. Sits directly downstream of the scheduler top level.

## Interface
Parameters:
- `DWIDTH`, 32, word width; matches the scheduler's `out_data`.
- `DEPTH`, 4, holding FIFO entries; power of two, ≥2.
- `TOKEN_W`, 8, token counter and burst width.
- `PERIOD_W`, 16, refill period counter width.

Ports:
- `clk`  in  1  clock; the block's single clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `en`  in  1  drain enable.
- `cfg_period`  in  PERIOD_W  cycles per token refill; 0 = unshaped.
- `cfg_burst`  in  TOKEN_W  token bucket ceiling.
- `sch_ready`  in  1  scheduler initialised; sticky high.
- `sch_out_valid`  in  1  scheduler head word valid.
- `sch_out_data`  in  DWIDTH  scheduler head word.
- `sch_out_deque_en`  out  1  pop request to scheduler.
- `tx_valid`  out  1  transmit word valid.
- `tx_data`  out  DWIDTH  transmit word.
- `tx_ready`  in  1  downstream accept.
- `busy`  out  1  state ≠ HALT and ≠ WAIT_RDY.
- `stat_sent`  out  32  words transmitted.
- `stat_stall`  out  32  backpressure cycles.

## Operation
- Pop: occurs at a rising edge where `sch_out_valid && sch_out_deque_en`. `sch_out_data` is sampled at that edge and pushed into the holding FIFO.
- `sch_out_deque_en = (state==RUN) && (count < DEPTH) && (cfg_period==0 || tokens != 0)`. It never depends combinationally on `sch_out_valid`.
- Transmit: `tx_valid = (count != 0)`, `tx_data` = FIFO head. A word is retired at an edge where `tx_valid && tx_ready`.
- A push and a retire in the same cycle leave `count` unchanged. Full FIFO blocks pops through `deque_en`; no overflow is possible.
- Token bucket: `pcnt` counts 0..`cfg_period`-1, and `refill` pulses on wrap. `tokens_next = min(tokens - pop + refill, cfg_burst)`.
  - When `cfg_period==0`, tokens and `pcnt` hold and are ignored.
  - When `cfg_burst==0` with shaping on, pops are permanently blocked.
- FSM:
  - WAIT_RDY → RUN when `sch_ready && en`.
  - WAIT_RDY → HALT when `sch_ready && !en`.
  - RUN → DRAIN when `!en`.
  - DRAIN → HALT when `count==0`. DRAIN → RUN when `en` reasserts.
  - HALT → RUN when `en`.
  - In DRAIN and HALT no pops are made; the FIFO keeps transmitting.
- Reset mid-operation: FIFO contents are discarded and state returns to WAIT_RDY. Any word popped from the scheduler but not transmitted is lost; this is accepted.

## Timing
- Reset values:
  - `sch_out_deque_en`, `tx_valid`, `busy` = 0.
  - `tx_data`, `stat_sent`, `stat_stall` = 0.
  - `tokens`, `pcnt`, `count` = 0. State = WAIT_RDY.
- Latency: pop at edge N → `tx_valid`=1 and `tx_data` = that word in cycle N+1. Sustained throughput is 1 word/cycle unshaped with `tx_ready` held high.
- Shaped steady state: 1 word per `cfg_period` cycles. After idle, up to `cfg_burst` back-to-back words.
- `tx_data` is stable while `tx_valid && !tx_ready`.
- FIFO pointers wrap modulo `DEPTH`. `count` is `$clog2(DEPTH)+1` bits wide.

## Configuration
- `PKT_DRAIN_STATS_EN` defined:
  - `stat_sent` increments on each retire.
  - `stat_stall` increments each cycle `tx_valid && !tx_ready`.
  - Both are 32-bit, wrap at 2^32, and clear only on reset.
- Not defined: both stat outputs are tied to 0 and no counter flops are built. Ports remain present.

## Test plan
- Reset release with `sch_ready`=0 for 10 cycles → `sch_out_deque_en`=0, `busy`=0. Then raise `sch_ready`, `en`=1 → `deque_en`=1 the next cycle.
- Unshaped, scheduler supplies 0x10..0x17 back-to-back, `tx_ready`=1 → `tx_data` 0x10..0x17 on 8 consecutive cycles, one cycle after each pop. `stat_sent`=8.
- `tx_ready`=0 with 6 words offered, DEPTH=4 → exactly 4 pops, then `deque_en`=0, and `stat_stall` counts every stalled cycle. Then raise `tx_ready` → remaining 2 words drain in order.
- `cfg_period`=4, `cfg_burst`=2, idle 20 cycles, then continuous supply → 2 back-to-back words, then 1 word every 4 cycles.
- Deassert `en` with 3 words buffered → no further pops, 3 words transmitted, state HALT, `busy`=0. Reassert `en` → pops resume the next cycle.
- Assert `rst_n`=0 mid-burst with 2 words buffered → `tx_valid`=0 immediately (async), and no buffered word appears after release.
